// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - multi-cycle conditional branch sequencer sharing an external ALU
module branch_sequencer #(
  parameter logic [2:0] ALU_ADD = 3'b001,
  parameter logic [2:0] ALU_SUB = 3'b010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  BranchOP,
  input  logic [15:0] offset,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] pc_plus4,
  input  logic        flush,
  input  logic        alu_gnt,
  input  logic        GT,
  input  logic        LT,
  input  logic        ET,
  input  logic [31:0] ALU_out,
  output logic        alu_req,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        pc_write,
  output logic [31:0] pc_next,
  output logic        taken,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CMP    = 2'd1,
    S_TGT    = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] offset_q, offset_d;
  logic [31:0] rs_q, rs_d;
  logic [31:0] rt_q, rt_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] target_q, target_d;
  logic        taken_q, taken_d;
  logic        cond_met;

  // Branch condition evaluated from the ALU flags while the compare is on the ALU
  always_comb begin
    cond_met = 1'b0;
    case (op_q)
      2'b00:   cond_met = ET;
      2'b01:   cond_met = !ET;
      2'b10:   cond_met = GT;
      default: cond_met = LT | ET;
    endcase
  end

  // State and operand registers; reset clears everything immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      offset_q <= 16'd0;
      rs_q     <= 32'd0;
      rt_q     <= 32'd0;
      pc4_q    <= 32'd0;
      target_q <= 32'd0;
      taken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      offset_q <= offset_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      pc4_q    <= pc4_d;
      target_q <= target_d;
      taken_q  <= taken_d;
    end
  end

  // Next-state and register update; flush during CMP/TGT drops the branch entirely
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    offset_d = offset_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    pc4_d    = pc4_q;
    target_d = target_q;
    taken_d  = taken_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d     = BranchOP;
          offset_d = offset;
          rs_d     = rs_val;
          rt_d     = rt_val;
          pc4_d    = pc_plus4;
          target_d = 32'd0;
          taken_d  = 1'b0;
          state_d  = S_CMP;
        end
      end
      S_CMP, S_TGT: begin
        if (flush) begin
          op_d     = 2'b00;
          offset_d = 16'd0;
          rs_d     = 32'd0;
          rt_d     = 32'd0;
          pc4_d    = 32'd0;
          target_d = 32'd0;
          taken_d  = 1'b0;
          state_d  = S_IDLE;
        end else if (alu_gnt) begin
          if (state_q == S_CMP) begin
            taken_d = cond_met;
            state_d = S_TGT;
          end else begin
            target_d = ALU_out;
            state_d  = S_COMMIT;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state only
  always_comb begin
    alu_req  = 1'b0;
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    alu_op   = 3'b000;
    pc_write = 1'b0;
    done     = 1'b0;
    taken    = 1'b0;
    pc_next  = pc4_q;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_CMP: begin
        alu_req = 1'b1;
        alu_a   = rs_q;
        alu_b   = rt_q;
        alu_op  = ALU_SUB;
      end
      S_TGT: begin
        alu_req = 1'b1;
        alu_a   = pc4_q;
        alu_b   = {{14{offset_q[15]}}, offset_q, 2'b00};
        alu_op  = ALU_ADD;
      end
      S_COMMIT: begin
        pc_write = 1'b1;
        done     = 1'b1;
        taken    = taken_q;
        pc_next  = taken_q ? target_q : pc4_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - scoreboard bench for branch_sequencer
module tb_branch_sequencer;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;

  logic        clk = 1'b0;
  logic        reset, start, flush, alu_gnt;
  logic [1:0]  branch_op;
  logic [15:0] offset;
  logic [31:0] rs_val, rt_val, pc_plus4;
  logic        gt, lt, et;
  logic [31:0] alu_out;
  logic        alu_req, pc_write, taken, busy, done;
  logic [31:0] alu_a, alu_b, pc_next;
  logic [2:0]  alu_op;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        tk;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  branch_sequencer #(.ALU_ADD(ALU_ADD), .ALU_SUB(ALU_SUB)) dut (
    .clk(clk), .reset(reset), .start(start), .BranchOP(branch_op), .offset(offset),
    .rs_val(rs_val), .rt_val(rt_val), .pc_plus4(pc_plus4), .flush(flush),
    .alu_gnt(alu_gnt), .GT(gt), .LT(lt), .ET(et), .ALU_out(alu_out),
    .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .pc_write(pc_write), .pc_next(pc_next), .taken(taken), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // External shared ALU
  always_comb begin
    alu_out = 32'd0;
    if (alu_op == ALU_ADD) alu_out = alu_a + alu_b;
    else if (alu_op == ALU_SUB) alu_out = alu_a - alu_b;
  end
  assign et = (alu_a == alu_b);
  assign gt = ($signed(alu_a) > $signed(alu_b));
  assign lt = ($signed(alu_a) < $signed(alu_b));

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [31:0] pc4, input logic [15:0] off);
    exp_t e;
    logic [31:0] tgt;
    tgt = pc4 + 32'($signed(off)) * 32'd4;
    case (op)
      2'b00:   e.tk = (rs == rt);
      2'b01:   e.tk = (rs != rt);
      2'b10:   e.tk = ($signed(rs) > $signed(rt));
      default: e.tk = ($signed(rs) <= $signed(rt));
    endcase
    e.pc = e.tk ? tgt : pc4;
    return e;
  endfunction

  // Drives one start pulse (called just after a rising edge); operand inputs are scrambled afterwards
  task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] pc4, input logic [15:0] off, input bit expect_commit);
    branch_op = op; rs_val = rs; rt_val = rt; pc_plus4 = pc4; offset = off; start = 1'b1;
    if (expect_commit) sb.push_back(model(op, rs, rt, pc4, off));
    @(posedge clk); #1;
    start = 1'b0;
    branch_op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
    pc_plus4 = $urandom; offset = 16'($urandom);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; flush = 1'b0; alu_gnt = 1'b1;
    branch_op = 2'b00; offset = 16'd0; rs_val = 32'd0; rt_val = 32'd0; pc_plus4 = 32'd0;
    #1;
    checks++;
    if ({alu_req, alu_a, alu_b, alu_op, pc_write, pc_next, taken, busy, done} !== 104'd0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b a=%h b=%h op=%b pcw=%b pcn=%h tk=%b busy=%b done=%b, want all 0",
               alu_req, alu_a, alu_b, alu_op, pc_write, pc_next, taken, busy, done);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b pc_write=%b, want 0 0", busy, pc_write);
    end
    @(posedge clk); #1;
  endtask

  logic [1:0]  t_op[6]  = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11};
  logic [31:0] t_rs[6]  = '{32'd5, 32'd7, 32'd3, 32'd3, 32'hFFFFFFFE, 32'h80000000};
  logic [31:0] t_rt[6]  = '{32'd5, 32'd7, 32'd3, 32'd3, 32'd1, 32'h7FFFFFFF};
  logic [31:0] t_pc[6]  = '{32'h100, 32'h200, 32'h40, 32'h40, 32'h1000, 32'hFFFFFFFC};
  logic [15:0] t_off[6] = '{16'h0004, 16'hFFFF, 16'hFFF0, 16'hFFF0, 16'h0010, 16'h0001};
  logic        t_tk[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] t_pn[6]  = '{32'h110, 32'h200, 32'h0, 32'h40, 32'h1000, 32'h0};

  task automatic test_branches;
    exp_t e;
    int lat;
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_rs[i], t_rt[i], t_pc[i], t_off[i], 1'b1);
      lat = 0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (c == 1) begin
          checks++;
          if (alu_req !== 1'b1 || alu_op !== ALU_SUB || alu_a !== t_rs[i] || alu_b !== t_rt[i] || busy !== 1'b1) begin
            errors++;
            $display("FAIL cmp_drive[%0d]: req=%b op=%b a=%h b=%h busy=%b, want 1 %b %h %h 1",
                     i, alu_req, alu_op, alu_a, alu_b, busy, ALU_SUB, t_rs[i], t_rt[i]);
          end
        end
        if (c == 2) begin
          checks++;
          if (alu_req !== 1'b1 || alu_op !== ALU_ADD || alu_a !== t_pc[i] ||
              alu_b !== 32'($signed(t_off[i])) * 32'd4) begin
            errors++;
            $display("FAIL tgt_drive[%0d]: req=%b op=%b a=%h b=%h, want 1 %b %h %h",
                     i, alu_req, alu_op, alu_a, alu_b, ALU_ADD, t_pc[i], 32'($signed(t_off[i])) * 32'd4);
          end
        end
        if (pc_write === 1'b1) begin
          lat = c;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow[%0d]: pc_write with no expected branch", i);
          end else begin
            e = sb.pop_front();
            if (taken !== e.tk || pc_next !== e.pc || done !== 1'b1 || taken !== t_tk[i] || pc_next !== t_pn[i]) begin
              errors++;
              $display("FAIL commit[%0d]: taken=%b pc_next=%h done=%b, want %b %h 1", i, taken, pc_next, done, t_tk[i], t_pn[i]);
            end
          end
          break;
        end
        @(posedge clk); #1;
      end
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d cycles, want 3", i, lat);
        sb.delete();
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (pc_write !== 1'b0 || busy !== 1'b0 || pc_next !== t_pc[i]) begin
        errors++;
        $display("FAIL after_commit[%0d]: pc_write=%b busy=%b pc_next=%h, want 0 0 %h", i, pc_write, busy, pc_next, t_pc[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall;
    exp_t e;
    int lat = 0;
    alu_gnt = 1'b0;
    issue(2'b00, 32'd9, 32'd9, 32'h300, 16'h0002, 1'b1);
    for (int c = 1; c <= 14; c++) begin
      alu_gnt = (c == 4 || c == 7);
      @(negedge clk);
      if (c <= 4) begin
        checks++;
        if (alu_op !== ALU_SUB || alu_a !== 32'd9 || alu_b !== 32'd9) begin
          errors++;
          $display("FAIL stall_cmp[c%0d]: op=%b a=%h b=%h, want %b 9 9", c, alu_op, alu_a, alu_b, ALU_SUB);
        end
      end else if (c <= 7) begin
        checks++;
        if (alu_op !== ALU_ADD || alu_a !== 32'h300 || alu_b !== 32'h8) begin
          errors++;
          $display("FAIL stall_tgt[c%0d]: op=%b a=%h b=%h, want %b 300 8", c, alu_op, alu_a, alu_b, ALU_ADD);
        end
      end
      if (pc_write === 1'b1) begin
        lat = c;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL stall_sb_underflow: pc_write with no expected branch");
        end else begin
          e = sb.pop_front();
          if (taken !== e.tk || pc_next !== e.pc) begin
            errors++;
            $display("FAIL stall_commit: taken=%b pc_next=%h, want %b %h", taken, pc_next, e.tk, e.pc);
          end
        end
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL stall_latency: got %0d cycles, want 8", lat);
      sb.delete();
    end
    alu_gnt = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    int writes = 0;
    // flush while the target add is on the ALU
    issue(2'b00, 32'd1, 32'd1, 32'h500, 16'h0004, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pc_write !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_tgt: busy=%b pc_write=%b done=%b, want 0 0 0", busy, pc_write, done);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (pc_write === 1'b1) writes++;
    end
    checks++;
    if (writes != 0) begin
      errors++;
      $display("FAIL flush_no_write: got %0d pc_writes, want 0", writes);
    end
    @(posedge clk); #1;
    // flush together with start in IDLE
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_idle: busy=%b, want 0", busy);
    end
    @(posedge clk); #1;
    // flush arriving in COMMIT does not stop the write
    issue(2'b01, 32'd1, 32'd2, 32'h600, 16'h0001, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (pc_write !== 1'b1 || done !== 1'b1 || pc_next !== 32'h604 || sb.size() != 1) begin
      errors++;
      $display("FAIL flush_commit: pc_write=%b done=%b pc_next=%h, want 1 1 604", pc_write, done, pc_next);
    end
    if (pc_write === 1'b1 && sb.size() != 0) void'(sb.pop_front());
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
  endtask

  task automatic test_start_while_busy;
    exp_t e;
    int dones = 0;
    issue(2'b10, 32'd10, 32'd3, 32'h800, 16'h0003, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      start = (c <= 3);
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL busy_start_extra_done: done at cycle %0d with no expected branch", c);
        end else begin
          e = sb.pop_front();
          if (taken !== e.tk || pc_next !== e.pc) begin
            errors++;
            $display("FAIL busy_start_commit: taken=%b pc_next=%h, want %b %h", taken, pc_next, e.tk, e.pc);
          end
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL busy_start_dones: got %0d, want 1", dones);
    end
    sb.delete();
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int k = 0;
    int writes = 0;
    for (int c = 0; c <= 14; c++) begin
      start = (c <= 8);
      if (c % 4 == 0 && k < 3) begin
        branch_op = 2'(k); rs_val = 32'(k + 4); rt_val = 32'd5;
        pc_plus4 = 32'h1000 * 32'(k + 1); offset = 16'(k + 1);
        sb.push_back(model(branch_op, rs_val, rt_val, pc_plus4, offset));
        k++;
      end
      @(negedge clk);
      checks++;
      if (pc_write !== ((c % 4 == 3) && c <= 11)) begin
        errors++;
        $display("FAIL b2b_strobe[c%0d]: pc_write=%b, want %b", c, pc_write, (c % 4 == 3) && c <= 11);
      end
      if (pc_write === 1'b1) begin
        writes++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_sb_underflow[c%0d]: pc_write with no expected branch", c);
        end else begin
          e = sb.pop_front();
          if (taken !== e.tk || pc_next !== e.pc) begin
            errors++;
            $display("FAIL b2b_commit[c%0d]: taken=%b pc_next=%h, want %b %h", c, taken, pc_next, e.tk, e.pc);
          end
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (writes != 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d writes, %0d left, want 3 0", writes, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int lat = 0;
    issue(2'b00, 32'd2, 32'd2, 32'h900, 16'h0004, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (alu_req !== 1'b0 || busy !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 ||
        alu_op !== 3'b000 || pc_next !== 32'd0 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: req=%b busy=%b a=%h b=%h op=%b pcn=%h pcw=%b, want all 0",
               alu_req, busy, alu_a, alu_b, alu_op, pc_next, pc_write);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    issue(2'b00, 32'd5, 32'd5, 32'h100, 16'h0004, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (pc_write === 1'b1) begin
        lat = c;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL reset_mid_sb_underflow: pc_write with no expected branch");
        end else begin
          e = sb.pop_front();
          if (taken !== e.tk || pc_next !== e.pc) begin
            errors++;
            $display("FAIL reset_mid_commit: taken=%b pc_next=%h, want %b %h", taken, pc_next, e.tk, e.pc);
          end
        end
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL reset_mid_latency: got %0d cycles, want 3", lat);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_branches;
    test_stall;
    test_flush;
    test_start_while_busy;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
